// File: rtl/ahb_lite_mem_bist_if.sv
// AHB-Lite bus bundle between the memory BIST master and the memory controller.
// master modport: drives HSEL/HADDR/HBURST/HSIZE/HTRANS/HWDATA/HWRITE,
//                 receives HRDATA/HREADY/HRESP.
// slave modport:  the mirror image.
interface ahb_lite_mem_bist_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HBURST, HSIZE, HTRANS, HWDATA, HWRITE,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HBURST, HSIZE, HTRANS, HWDATA, HWRITE,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_mem_bist.sv
// Memory BIST over AHB-Lite: writes a seeded pattern to WORDS consecutive words
// starting at ADDR_BASE, reads them back and counts mismatches / error responses.
// Ports:
//   HCLK       - clock, rising edge
//   HRESET     - synchronous active-high reset
//   start      - one-cycle run request (ignored while busy)
//   busy       - run in progress
//   done       - run finished, results valid
//   pass       - no error in the last run (valid with done)
//   err_count  - saturating error count
//   err_addr   - HADDR of the first failing word
//   bus        - AHB-Lite master port
module ahb_lite_mem_bist #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned WORDS     = 16,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_count,
  output logic [31:0]                err_addr,
  ahb_lite_mem_bist_if.master        bus
);

  localparam logic [1:0]  TransIdle   = 2'b00;
  localparam logic [1:0]  TransNonseq = 2'b10;
  localparam logic [16:0] LastIdx     = 17'(WORDS - 1);

  typedef enum logic [2:0] {StIdle, StWr, StWrEnd, StRd, StRdEnd, StDone} state_e;

  state_e      state_q, state_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        rd_phase_q, rd_phase_d;   // a read data phase is in flight
  logic [31:0] rd_exp_q, rd_exp_d;       // expected data of that read
  logic [31:0] rd_addr_q, rd_addr_d;     // address of that read
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_seen_q, err_seen_d;
  logic        done_q, done_d;

  logic [31:0] cur_addr;
  logic [31:0] cur_pat;
  logic        addr_phase;
  logic        rd_error;

  assign cur_addr   = ADDR_BASE + {13'd0, idx_q, 2'b00};
  assign cur_pat    = SEED ^ cur_addr;
  assign addr_phase = (state_q == StWr) || (state_q == StRd);
  assign rd_error   = rd_phase_q && bus.HREADY && (bus.HRESP || (bus.HRDATA != rd_exp_q));

  assign busy       = (state_q == StWr) || (state_q == StWrEnd) ||
                      (state_q == StRd) || (state_q == StRdEnd);
  assign done       = done_q;
  assign pass       = done_q && (err_cnt_q == 16'd0);
  assign err_count  = err_cnt_q;
  assign err_addr   = err_addr_q;

  assign bus.HSEL   = busy;
  assign bus.HBURST = 3'b000;
  assign bus.HSIZE  = 3'b010;
  assign bus.HTRANS = addr_phase ? TransNonseq : TransIdle;
  assign bus.HWRITE = (state_q == StWr);
  assign bus.HADDR  = addr_phase ? cur_addr : 32'd0;
  assign bus.HWDATA = hwdata_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hwdata_d   = hwdata_q;
    rd_phase_d = rd_phase_q;
    rd_exp_d   = rd_exp_q;
    rd_addr_d  = rd_addr_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_seen_d = err_seen_q;

    // Everything on the bus advances only on edges where the slave is ready.
    if (bus.HREADY) begin
      rd_phase_d = (state_q == StRd);
    end

    if (rd_error) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (!err_seen_q) begin
        err_seen_d = 1'b1;
        err_addr_d = rd_addr_q;
      end
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StWr;
          idx_d      = 17'd0;
          err_cnt_d  = 16'd0;
          err_addr_d = 32'd0;
          err_seen_d = 1'b0;
        end
      end
      StWr: begin
        if (bus.HREADY) begin
          hwdata_d = cur_pat;
          idx_d    = idx_q + 17'd1;
          if (idx_q == LastIdx) begin
            state_d = StWrEnd;
          end
        end
      end
      StWrEnd: begin
        if (bus.HREADY) begin
          idx_d   = 17'd0;
          state_d = StRd;
        end
      end
      StRd: begin
        if (bus.HREADY) begin
          rd_exp_d  = cur_pat;
          rd_addr_d = cur_addr;
          idx_d     = idx_q + 17'd1;
          if (idx_q == LastIdx) begin
            state_d = StRdEnd;
          end
        end
      end
      StRdEnd: begin
        if (bus.HREADY) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // done is a registered strobe one cycle behind entry to DONE; it drops on the
    // same edge that accepts a re-run.
    done_d = (state_q == StDone) && (state_d == StDone);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= StIdle;
      idx_q      <= 17'd0;
      hwdata_q   <= 32'd0;
      rd_phase_q <= 1'b0;
      rd_exp_q   <= 32'd0;
      rd_addr_q  <= 32'd0;
      err_cnt_q  <= 16'd0;
      err_addr_q <= 32'd0;
      err_seen_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hwdata_q   <= hwdata_d;
      rd_phase_q <= rd_phase_d;
      rd_exp_q   <= rd_exp_d;
      rd_addr_q  <= rd_addr_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_seen_q <= err_seen_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_bist.sv
// Bench for ahb_lite_mem_bist: a bus agent models the memory slave and checks
// every transfer against a queue of expected transfers; run results are checked
// against a queue of expected outcomes when done rises.
module tb_ahb_lite_mem_bist;
  localparam int unsigned W    = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] err_addr;

  ahb_lite_mem_bist_if bus_if ();

  ahb_lite_mem_bist #(
    .ADDR_BASE (BASE),
    .WORDS     (W),
    .SEED      (SEED)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .err_addr  (err_addr),
    .bus       (bus_if)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    int unsigned cnt;
    logic [31:0] addr;
    bit          pass;
    int unsigned cyc0;
    int unsigned stall0;
  } res_t;

  xfer_t xq[$];
  res_t  rq[$];

  // Slave fault controls, set by stimulus before each start.
  bit          ovr_en   [W];
  logic [31:0] ovr_val  [W];
  bit          resp_err [W];
  int unsigned wait_pct = 0;
  bit          dir_stall_en = 1'b0;
  bit          noise_en = 1'b0;
  bit          end_req = 1'b0;
  bit          end_ack = 1'b0;

  int unsigned cyc = 0;
  int unsigned stalls = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int i);
    return SEED ^ (BASE + 32'(4 * i));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model + monitor. Runs on the falling edge: it picks HREADY/HRDATA for the
  // coming rising edge and judges what that edge will complete.
  always @(negedge HCLK) begin : agent
    logic [31:0] mem [W];
    logic        rdy;
    xfer_t       x;
    res_t        r;
    bit          pend_v, pend_wr, prev_stall, rst_prev, done_prev;
    logic [31:0] pend_addr, pend_data;
    int          pend_idx, dir_used, idle_chk, busy_cnt;
    logic [31:0] p_haddr, p_hwdata;
    logic [1:0]  p_htrans;
    logic        p_hwrite;

    if (rst_prev) begin
      chk("rst_htrans", bus_if.HTRANS, 0);
      chk("rst_hwrite", bus_if.HWRITE, 0);
      chk("rst_haddr", bus_if.HADDR, 0);
      chk("rst_hwdata", bus_if.HWDATA, 0);
      chk("rst_hsel", bus_if.HSEL, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_err_addr", err_addr, 0);
      idle_chk = 6;
    end else if (idle_chk > 0) begin
      chk("idle_htrans", bus_if.HTRANS, 0);
      chk("idle_hsel", bus_if.HSEL, 0);
      idle_chk--;
    end

    if (prev_stall && !rst_prev) begin
      chk("hold_haddr", bus_if.HADDR, p_haddr);
      chk("hold_htrans", bus_if.HTRANS, p_htrans);
      chk("hold_hwrite", bus_if.HWRITE, p_hwrite);
      chk("hold_hwdata", bus_if.HWDATA, p_hwdata);
    end

    if (start && !busy) dir_used = 0;

    rdy = ($urandom_range(99) >= wait_pct);
    if (dir_stall_en && pend_v && pend_wr && pend_addr == BASE + 32'd4 && dir_used < 2) begin
      rdy = 1'b0;
      dir_used++;
    end
    bus_if.HREADY = rdy;
    if (pend_v && !pend_wr) begin
      bus_if.HRDATA = ovr_en[pend_idx] ? ovr_val[pend_idx] : mem[pend_idx];
      bus_if.HRESP  = resp_err[pend_idx];
    end else begin
      bus_if.HRDATA = $urandom;
      bus_if.HRESP  = noise_en ? 1'($urandom_range(1)) : 1'b0;
    end

    if (HRESET) begin
      xq.delete();
      rq.delete();
      pend_v     = 1'b0;
      prev_stall = 1'b0;
      busy_cnt   = 0;
    end else begin
      if (busy && !rdy) stalls++;
      prev_stall = busy && !rdy;
      p_haddr    = bus_if.HADDR;
      p_htrans   = bus_if.HTRANS;
      p_hwrite   = bus_if.HWRITE;
      p_hwdata   = bus_if.HWDATA;

      if (rdy) begin
        if (pend_v && pend_wr) begin
          chk("wr_data", bus_if.HWDATA, pend_data);
          mem[pend_idx] = bus_if.HWDATA;
        end
        pend_v = 1'b0;
        if (bus_if.HTRANS == 2'b10) begin
          if (xq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer: got addr %h write %b expected no transfer",
                     bus_if.HADDR, bus_if.HWRITE);
          end else begin
            x = xq.pop_front();
            chk("xfer_dir", bus_if.HWRITE, x.wr);
            chk("xfer_addr", bus_if.HADDR, x.addr);
            chk("xfer_hsel", bus_if.HSEL, 1);
            chk("xfer_hsize", bus_if.HSIZE, 3'b010);
            chk("xfer_hburst", bus_if.HBURST, 3'b000);
            pend_v    = 1'b1;
            pend_wr   = bus_if.HWRITE;
            pend_addr = bus_if.HADDR;
            pend_data = x.data;
            pend_idx  = int'(bus_if.HADDR[3:2]);
          end
        end
      end

      if (done && !done_prev) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          r = rq.pop_front();
          chk("err_count", err_count, r.cnt);
          chk("err_addr", err_addr, r.addr);
          chk("pass", pass, r.pass);
          chk("latency", cyc - r.cyc0, 2 * W + 3 + (stalls - r.stall0));
        end
      end

      busy_cnt = busy ? busy_cnt + 1 : 0;
      if (busy_cnt == 1000) begin
        checks++;
        failures++;
        $display("FAIL busy_timeout: got busy for %0d cycles expected completion", busy_cnt);
      end
    end

    done_prev = done;
    rst_prev  = HRESET;

    if (end_req && !end_ack) begin
      chk("xfers_left", xq.size(), 0);
      chk("results_left", rq.size(), 0);
      end_ack = 1'b1;
    end
  end

  task automatic clear_faults();
    for (int i = 0; i < W; i++) begin
      ovr_en[i]   = 1'b0;
      ovr_val[i]  = 32'd0;
      resp_err[i] = 1'b0;
    end
    wait_pct     = 0;
    dir_stall_en = 1'b0;
    noise_en     = 1'b0;
  endtask

  // Pulses start; if the BIST is idle, queues the transfers and outcome it must produce.
  task automatic issue_start();
    res_t r;
    @(posedge HCLK);
    #1;
    if (!busy) begin
      for (int i = 0; i < W; i++) xq.push_back('{wr: 1'b1, addr: BASE + 32'(4 * i), data: pat(i)});
      for (int i = 0; i < W; i++) xq.push_back('{wr: 1'b0, addr: BASE + 32'(4 * i), data: 32'd0});
      r.cnt  = 0;
      r.addr = 32'd0;
      for (int i = 0; i < W; i++) begin
        if (resp_err[i] || (ovr_en[i] && ovr_val[i] != pat(i))) begin
          if (r.cnt == 0) r.addr = BASE + 32'(4 * i);
          r.cnt++;
        end
      end
      r.pass   = (r.cnt == 0);
      r.cyc0   = cyc + 1;
      r.stall0 = stalls;
      rq.push_back(r);
    end
    start = 1'b1;
    @(posedge HCLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && !done; k++) @(posedge HCLK);
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  initial begin
    clear_faults();
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    repeat (8) @(posedge HCLK);

    // Clean zero-wait run.
    issue_start();
    wait_done();

    // Two wait states in the write data phase of word 1.
    dir_stall_en = 1'b1;
    issue_start();
    wait_done();
    clear_faults();

    // Read of 0x8 returns zero.
    ovr_en[2]  = 1'b1;
    ovr_val[2] = 32'd0;
    issue_start();
    wait_done();

    // All reads return zero, then a clean rerun clears the results.
    for (int i = 0; i < W; i++) begin
      ovr_en[i]  = 1'b1;
      ovr_val[i] = 32'd0;
    end
    issue_start();
    wait_done();
    clear_faults();
    issue_start();
    wait_done();

    // Reset during the read pass aborts the run.
    issue_start();
    for (int k = 0; k < 100 && !(bus_if.HTRANS == 2'b10 && !bus_if.HWRITE); k++) begin
      @(posedge HCLK);
      #1;
    end
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    repeat (8) @(posedge HCLK);

    // start during the write pass is ignored.
    issue_start();
    repeat (2) @(posedge HCLK);
    issue_start();
    wait_done();

    // Randomized runs: wait states, bus noise, corrupted reads and error responses.
    for (int n = 0; n < 10; n++) begin
      wait_pct = $urandom_range(40);
      noise_en = 1'b1;
      for (int i = 0; i < W; i++) begin
        ovr_en[i]   = ($urandom_range(3) == 0);
        ovr_val[i]  = ($urandom_range(1) == 1) ? pat(i) : pat(i) ^ (32'h1 << $urandom_range(31));
        resp_err[i] = ($urandom_range(5) == 0);
      end
      issue_start();
      wait_done();
    end
    clear_faults();

    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_ack; k++) @(posedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
